// File: rtl/trc_req_cond.sv
// Conditions a bouncing override push-button into a clean, time-limited sw request.
// Latency: held press reaches sw=1 after edge 3+DEB_CYC (2 sync + DEB_CYC debounce + 1 FSM register).
// Backpressure: none; presses that land during cooldown are dropped, not queued.
module trc_req_cond #(
  parameter int DEB_CYC  = 4,
  parameter int HOLD_CYC = 10,
  parameter int CD_CYC   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       sw,
  output logic [1:0] state,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_COOL = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEB_CYC - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);
  localparam logic [15:0] CD_LOAD   = 16'(CD_CYC - 1);

  logic        sync1;
  logic        btn_s;
  logic        deb_q;
  logic        deb_q_d;
  logic [15:0] deb_cnt;
  logic        rise;

  state_t      state_q;
  state_t      state_nxt;
  logic [15:0] hold_cnt;
  logic [15:0] hold_nxt;
  logic [15:0] cd_cnt;
  logic [15:0] cd_nxt;
  logic [7:0]  cnt_nxt;
  logic        sw_nxt;
  logic        accept;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
    end
  end

  // Debouncer: accept a new level only after DEB_CYC consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q   <= 1'b0;
      deb_q_d <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_q_d <= deb_q;
      if (btn_s == deb_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt < DEB_LAST) begin
        deb_cnt <= deb_cnt + 16'd1;
      end else begin
        deb_q   <= btn_s;
        deb_cnt <= '0;
      end
    end
  end

  // deb_q_d resets low, so a button held through reset still yields a rise.
  assign rise = deb_q & ~deb_q_d;

  // FSM and counter registers; sw is registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_cnt  <= '0;
      cd_cnt    <= '0;
      press_cnt <= '0;
      sw        <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      hold_cnt  <= hold_nxt;
      cd_cnt    <= cd_nxt;
      press_cnt <= cnt_nxt;
      sw        <= sw_nxt;
    end
  end

  // Next-state logic: rises start or extend HOLD, are ignored in COOL.
  always_comb begin
    state_nxt = state_q;
    hold_nxt  = hold_cnt;
    cd_nxt    = cd_cnt;
    cnt_nxt   = press_cnt;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HOLD;
          hold_nxt  = HOLD_LOAD;
          accept    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (rise) begin
          hold_nxt = HOLD_LOAD;
          accept   = 1'b1;
        end else if (hold_cnt == 16'd0) begin
          state_nxt = ST_COOL;
          cd_nxt    = CD_LOAD;
        end else begin
          hold_nxt = hold_cnt - 16'd1;
        end
      end
      ST_COOL: begin
        if (cd_cnt == 16'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          cd_nxt = cd_cnt - 16'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (accept && (press_cnt != 8'hFF)) begin
      cnt_nxt = press_cnt + 8'd1;
    end
    sw_nxt = (state_nxt == ST_HOLD);
  end

  assign state = state_q;

endmodule

// File: doc/trc_req_cond.md
TRC_REQ_COND -- requirements
Module: trc_req_cond

Interface
REQ-001 The block SHALL condition a raw override push-button into the clean sw level consumed by the traffic-light controller stage directly downstream.
REQ-002 The block SHALL have these parameters, one per line (name, default, meaning):
  DEB_CYC   4    consecutive stable cycles required to accept a level change (legal >=2)
  HOLD_CYC  10   cycles sw stays high per accepted request (legal >=1)
  CD_CYC    5    cooldown cycles after hold, presses ignored (legal >=1)
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk        in   1  single clock, rising edge
  reset      in   1  asynchronous, active-high reset
  btn_raw    in   1  raw asynchronous, bouncing button, high = pressed
  sw         out  1  override request to controller, registered
  state      out  2  FSM state: 00 IDLE, 01 HOLD, 10 COOL
  press_cnt  out  8  accepted-request count, saturating
REQ-004 There SHALL be one clock, clk; reset SHALL be asynchronous and active-high; all state SHALL update on the rising edge of clk only.

Function
REQ-005 btn_raw SHALL pass through a 2-flop synchronizer; the second flop output is btn_s.
REQ-006 The debouncer SHALL hold a stable level deb_q and a counter deb_cnt of at least 16 bits.
REQ-007 If btn_s == deb_q, deb_cnt SHALL clear to 0.
REQ-008 If btn_s != deb_q and deb_cnt < DEB_CYC-1, deb_cnt SHALL increment.
REQ-009 If btn_s != deb_q and deb_cnt == DEB_CYC-1, deb_q SHALL take btn_s and deb_cnt SHALL clear.
REQ-010 rise SHALL be deb_q high AND its one-cycle-delayed copy low; it is a one-cycle pulse.
REQ-011 In IDLE, rise SHALL move the FSM to HOLD, load the hold counter with HOLD_CYC-1, and count one accepted request.
REQ-012 In HOLD, a rise SHALL reload the hold counter with HOLD_CYC-1 and count one accepted request; HOLD is then extended.
REQ-013 In HOLD, when there is no rise and the hold counter is 0, the FSM SHALL move to COOL and load the cooldown counter with CD_CYC-1; otherwise the hold counter decrements.
REQ-014 In COOL, rise SHALL be ignored and not counted.
REQ-015 In COOL, when the cooldown counter is 0 the FSM SHALL move to IDLE; otherwise the cooldown counter decrements.
REQ-016 State encoding 11 SHALL go to IDLE on the next edge, with sw=0.
REQ-017 sw SHALL be registered and SHALL be 1 exactly in the cycles where state==HOLD.
REQ-018 Timing: HOLD SHALL last exactly HOLD_CYC cycles per unextended request; COOL SHALL last exactly CD_CYC cycles.
REQ-019 Latency: btn_raw rising before edge 1 and held stable SHALL give deb_q=1 after edge 2+DEB_CYC and sw=1 after edge 3+DEB_CYC.
REQ-020 Releases SHALL be debounced identically; a new request requires a debounced release followed by a debounced press.
REQ-021 press_cnt SHALL increment by 1 per accepted rise and SHALL saturate at 255, never wrapping.

Reset
REQ-022 While reset=1, the block SHALL force these values immediately, without waiting for clk: sync flops 0, deb_q 0, deb_cnt 0, both FSM counters 0, state IDLE, sw 0, press_cnt 0.
REQ-023 A reset asserted mid-HOLD or mid-COOL SHALL abort the operation.
REQ-024 After reset deasserts, a btn_raw already held high SHALL be treated as a new press and follow REQ-019 timing.

Verification (DEB_CYC=4, HOLD_CYC=10, CD_CYC=5)
REQ-025 Bounce: btn_raw toggles every 2 cycles for 20 cycles, then 0 -> sw never 1, press_cnt=0, state stays 00.
REQ-026 Clean press: btn_raw=1 from before edge 1, held 40 cycles -> sw=1 after edge 7 for exactly 10 cycles, state 10 for 5 cycles, then 00, press_cnt=1.
REQ-027 Extend: a second debounced press accepted during HOLD -> sw stays 1 until 10 cycles after the second rise, press_cnt=2.
REQ-028 Cooldown: a debounced press whose rise lands in COOL -> ignored, state returns to 00 on schedule, press_cnt unchanged.
REQ-029 Reset mid-HOLD: reset=1 asynchronously between edges -> sw=0 and state=00 before the next edge, press_cnt=0.
REQ-030 Saturation: 260 clean press/release pairs, each spaced beyond HOLD_CYC+CD_CYC+2*DEB_CYC+4 cycles -> press_cnt=255 and holds.
